// File: rtl/da_fir4_serial_pkg.sv
// Shared constants for the bit-serial DA FIR: tap coefficients, FSM encoding
// and default widths.
package da_fir4_serial_pkg;

   localparam int DATA_WIDTH_DEF  = 8;
   localparam int TABLE_WIDTH_DEF = 4;
   localparam int COEFF_WIDTH_DEF = 12;
   localparam int OUT_WIDTH_DEF   = 20;

   // Index i is the coefficient of tap i, which drives table address bit i.
   localparam logic [3:0][11:0] COEFFS = {12'd510, 12'd341, 12'd132, 12'd41};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/da_coeff_rom.sv
// Combinational 16-entry DA partial-sum table: each entry is the sum of the
// coefficients whose address bit is set.
module da_coeff_rom
   import da_fir4_serial_pkg::*;
#(
   parameter int TABLE_WIDTH = TABLE_WIDTH_DEF,
   parameter int COEFF_WIDTH = COEFF_WIDTH_DEF
) (
   input  logic [TABLE_WIDTH-1:0] addr,
   output logic [COEFF_WIDTH-1:0] data
);

   always_comb begin
      data = '0;
      for (int i = 0; i < TABLE_WIDTH; i++)
         if (addr[i]) data = data + COEFF_WIDTH'(COEFFS[i]);
   end

endmodule

// File: rtl/da_fir4_serial.sv
// Bit-serial distributed-arithmetic 4-tap FIR: one bit slice of all taps per
// cycle addresses the partial-sum table, accumulated LSB first, sign slice subtracted.
module da_fir4_serial
   import da_fir4_serial_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int TABLE_WIDTH = TABLE_WIDTH_DEF,
   parameter int COEFF_WIDTH = COEFF_WIDTH_DEF,
   parameter int OUT_WIDTH   = OUT_WIDTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   input  logic [DATA_WIDTH-1:0]       in_data,
   output logic                        in_ready,
   output logic                        out_valid,
   output logic signed [OUT_WIDTH-1:0] out_data
);

   localparam int CNT_W = $clog2(DATA_WIDTH);

   state_t                                  state, state_nxt;
   logic [TABLE_WIDTH-1:0][DATA_WIDTH-1:0]  taps, wregs;
   logic [CNT_W-1:0]                        count;
   logic [TABLE_WIDTH-1:0]                  addr;
   logic [COEFF_WIDTH-1:0]                  t_val;
   logic signed [OUT_WIDTH-1:0]             acc, acc_nxt, term;
   logic                                    last;

   for (genvar g = 0; g < TABLE_WIDTH; g++) begin : g_addr
      assign addr[g] = wregs[g][0];
   end

   da_coeff_rom #(.TABLE_WIDTH(TABLE_WIDTH), .COEFF_WIDTH(COEFF_WIDTH)) u_rom (
      .addr (addr),
      .data (t_val)
   );

   assign last = (32'(count) == DATA_WIDTH - 1);

   // The final slice carries the sign bit of every tap, so its weight is negative.
   always_comb begin
      term    = {{(OUT_WIDTH-COEFF_WIDTH){1'b0}}, t_val} << count;
      acc_nxt = last ? acc - term : acc + term;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = BUSY;
         BUSY:    if (last)     state_nxt = DONE;
         DONE:                  state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // out_data is captured with the final sum so it is already valid while DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         taps     <= '0;
         wregs    <= '0;
         acc      <= '0;
         count    <= '0;
         out_data <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               taps  <= {taps[TABLE_WIDTH-2:0], in_data};
               wregs <= {taps[TABLE_WIDTH-2:0], in_data};
               acc   <= '0;
               count <= '0;
            end
            BUSY: begin
               for (int i = 0; i < TABLE_WIDTH; i++) wregs[i] <= wregs[i] >> 1;
               acc   <= acc_nxt;
               count <= count + CNT_W'(1);
               if (last) out_data <= acc_nxt;
            end
            default: ;
         endcase
      end
   end

endmodule
